cp0_intc: RTL and testbench



---
 rtl/cp0_intc.sv | 193 +++++++++++++++++++
 tb/tb_cp0_intc.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_intc.sv
// CP0 interrupt controller: per-line level/edge pending, mask + global enable,
// fixed priority (line 0 highest), vectored request and nested EPC/level stack.

module cp0_intc_line (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  input  logic edge_mode,
  input  logic clr,
  output logic pend
);
  logic s, p;

  // A fresh edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= 1'b0;
      p    <= 1'b0;
      pend <= 1'b0;
    end else begin
      s <= irq_in;
      p <= s;
      if (!edge_mode)  pend <= s;
      else if (s & ~p) pend <= 1'b1;
      else if (clr)    pend <= 1'b0;
    end
  end
endmodule

module cp0_intc #(
  parameter int          NUM_IRQ    = 8,
  parameter int          NEST_DEPTH = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_4180,
  parameter logic [31:0] VEC_STRIDE = 32'h20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               irq_ack,
  input  logic [31:0]        epc_in,
  input  logic               eret,
  input  logic               cp_we,
  input  logic [4:0]         cp_wa,
  input  logic [31:0]        cp_wd,
  input  logic [4:0]         cp_ra,
  output logic [31:0]        cp_rd,
  output logic               irq_req,
  output logic [3:0]         irq_id,
  output logic [31:0]        irq_vec,
  output logic [31:0]        epc_out,
  output logic [3:0]         depth_out,
  output logic [31:0]        status_out,
  output logic [31:0]        cause_out
);
  localparam int          SW        = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
  localparam logic [4:0]  LVL_IDLE  = 5'(NUM_IRQ);
  localparam logic [3:0]  DEPTH_MAX = 4'(NEST_DEPTH);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t             state, state_d;
  logic [NUM_IRQ-1:0] im, mode, pend, clr;
  logic               ie;
  logic [4:0]         level;
  logic [3:0]         depth;
  logic [31:0]        stk_epc [NEST_DEPTH];
  logic [4:0]         stk_lvl [NEST_DEPTH];
  logic               stk_ie  [NEST_DEPTH];
  logic [SW-1:0]      push_idx, top_idx;

  logic wr_status, wr_epc, wr_mode, wr_clear;
  assign wr_status = cp_we && (cp_wa == 5'd12);
  assign wr_epc    = cp_we && (cp_wa == 5'd14);
  assign wr_mode   = cp_we && (cp_wa == 5'd22);
  assign wr_clear  = cp_we && (cp_wa == 5'd23);

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
    cp0_intc_line u_line (
      .clk       (clk),
      .rst       (rst),
      .irq_in    (irq_in[g]),
      .edge_mode (mode[g]),
      .clr       (clr[g]),
      .pend      (pend[g])
    );
  end

  // Priority pick over pending & mask; widened so a 4-bit id can index it.
  logic [15:0] pend_x, im_x;
  logic [3:0]  cand;
  logic        cand_vld;
  assign pend_x = 16'(pend);
  assign im_x   = 16'(im);

  always_comb begin
    cand     = 4'd0;
    cand_vld = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i] && im[i]) begin
        cand     = i[3:0];
        cand_vld = 1'b1;
      end
    end
  end

  logic room, elig_new, elig_hold, ack_take, pop;
  assign room      = depth < DEPTH_MAX;
  assign elig_new  = ie && cand_vld && ({1'b0, cand} < level) && room;
  assign elig_hold = ie && pend_x[irq_id] && im_x[irq_id] && ({1'b0, irq_id} < level) && room;
  assign ack_take  = irq_ack && (state == REQ);
  assign pop       = eret && (depth != 4'd0) && !ack_take;

  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++)
      clr[i] = (ack_take && (irq_id == 4'(i))) || (wr_clear && cp_wd[i]);
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (elig_new) state_d = REQ;
      REQ:  if (ack_take || !elig_hold) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign push_idx = SW'(depth);
  assign top_idx  = SW'(depth - 4'd1);

  // Status write lands first so a same-cycle ack/eret can override IE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      irq_id <= 4'd0;
      ie     <= 1'b0;
      im     <= '0;
      mode   <= '0;
      level  <= LVL_IDLE;
      depth  <= 4'd0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        stk_epc[i] <= 32'd0;
        stk_lvl[i] <= 5'd0;
        stk_ie[i]  <= 1'b0;
      end
    end else begin
      state <= state_d;
      if (state == IDLE && elig_new) irq_id <= cand;
      if (wr_status) begin
        im <= cp_wd[8 +: NUM_IRQ];
        ie <= cp_wd[0];
      end
      if (wr_mode) mode <= cp_wd[NUM_IRQ-1:0];
      if (ack_take) begin
        stk_epc[push_idx] <= epc_in;
        stk_lvl[push_idx] <= level;
        stk_ie[push_idx]  <= ie;
        level             <= {1'b0, irq_id};
        ie                <= 1'b0;
        depth             <= depth + 4'd1;
      end else if (pop) begin
        level <= stk_lvl[top_idx];
        ie    <= stk_ie[top_idx];
        depth <= depth - 4'd1;
      end else if (wr_epc && depth != 4'd0) begin
        stk_epc[top_idx] <= cp_wd;
      end
    end
  end

  assign irq_req   = (state == REQ);
  assign irq_vec   = VEC_BASE + 32'(irq_id) * VEC_STRIDE;
  assign depth_out = depth;
  assign epc_out   = (depth != 4'd0) ? stk_epc[top_idx] : 32'd0;

  always_comb begin
    status_out               = 32'd0;
    status_out[0]            = ie;
    status_out[8 +: NUM_IRQ] = im;
    cause_out                = 32'd0;
    cause_out[8 +: NUM_IRQ]  = pend;
    cause_out[5:2]           = (level == LVL_IDLE) ? 4'hF : level[3:0];
  end

  always_comb begin
    case (cp_ra)
      5'd12:   cp_rd = status_out;
      5'd13:   cp_rd = cause_out;
      5'd14:   cp_rd = epc_out;
      5'd22:   cp_rd = 32'(mode);
      default: cp_rd = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_cp0_intc.sv
// Bench for cp0_intc: directed scenarios plus random traffic, every cycle
// compared against a queue-based behavioural model of the CP0 interrupt rules.

module tb_cp0_intc;
  localparam int N  = 8;
  localparam int ND = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_in;
  logic          irq_ack, eret, cp_we;
  logic [31:0]   epc_in, cp_wd;
  logic [4:0]    cp_wa, cp_ra;
  logic [31:0]   cp_rd, irq_vec, epc_out, status_out, cause_out;
  logic          irq_req;
  logic [3:0]    irq_id, depth_out;

  cp0_intc #(.NUM_IRQ(N), .NEST_DEPTH(ND)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .irq_ack(irq_ack), .epc_in(epc_in),
    .eret(eret), .cp_we(cp_we), .cp_wa(cp_wa), .cp_wd(cp_wd), .cp_ra(cp_ra),
    .cp_rd(cp_rd), .irq_req(irq_req), .irq_id(irq_id), .irq_vec(irq_vec),
    .epc_out(epc_out), .depth_out(depth_out), .status_out(status_out),
    .cause_out(cause_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model
  typedef struct {
    logic [31:0] epc;
    int          lvl;
    bit          ie;
  } frame_t;

  bit [N-1:0] m_s, m_p, m_pend, m_mode, m_im;
  bit         m_ie, m_req;
  int         m_level, m_id;
  frame_t     m_stk[$];

  function automatic int cand_m();
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_im[i]) return i;
    return -1;
  endfunction

  function automatic bit elig_m(input int id);
    if (id < 0) return 1'b0;
    return m_ie && m_pend[id] && m_im[id] && (id < m_level) && (m_stk.size() < ND);
  endfunction

  function automatic logic [31:0] status_m();
    return (32'(m_im) << 8) | 32'(m_ie);
  endfunction

  function automatic logic [31:0] cause_m();
    int a;
    a = (m_level == N) ? 15 : m_level;
    return (32'(m_pend) << 8) | (32'(a) << 2);
  endfunction

  function automatic logic [31:0] epc_m();
    return (m_stk.size() > 0) ? m_stk[m_stk.size()-1].epc : 32'd0;
  endfunction

  function automatic logic [31:0] rd_m(input logic [4:0] a);
    case (a)
      5'd12:   return status_m();
      5'd13:   return cause_m();
      5'd14:   return epc_m();
      5'd22:   return 32'(m_mode);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    bit         ack, pop, nreq, old_ie;
    int         nid, c;
    bit [N-1:0] npend;
    frame_t     f;
    if (rst) begin
      m_s = '0; m_p = '0; m_pend = '0; m_mode = '0; m_im = '0;
      m_ie = 1'b0; m_level = N; m_req = 1'b0; m_id = 0;
      m_stk.delete();
      return;
    end
    ack    = irq_ack && m_req;
    pop    = eret && (m_stk.size() > 0) && !ack;
    old_ie = m_ie;
    nreq   = m_req;
    nid    = m_id;
    if (!m_req) begin
      c = cand_m();
      if (elig_m(c)) begin nreq = 1'b1; nid = c; end
    end else if (ack || !elig_m(m_id)) begin
      nreq = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (!m_mode[i])                npend[i] = m_s[i];
      else if (m_s[i] && !m_p[i])    npend[i] = 1'b1;
      else if ((ack && m_id == i) || (cp_we && cp_wa == 5'd23 && cp_wd[i])) npend[i] = 1'b0;
      else                           npend[i] = m_pend[i];
    end
    if (cp_we && cp_wa == 5'd12) begin m_im = cp_wd[8 +: N]; m_ie = cp_wd[0]; end
    if (cp_we && cp_wa == 5'd22) m_mode = cp_wd[N-1:0];
    if (ack) begin
      f.epc = epc_in; f.lvl = m_level; f.ie = old_ie;
      m_stk.push_back(f);
      m_level = m_id;
      m_ie    = 1'b0;
    end else if (pop) begin
      f = m_stk.pop_back();
      m_level = f.lvl;
      m_ie    = f.ie;
    end else if (cp_we && cp_wa == 5'd14 && m_stk.size() > 0) begin
      f = m_stk.pop_back();
      f.epc = cp_wd;
      m_stk.push_back(f);
    end
    m_pend = npend;
    m_p    = m_s;
    m_s    = irq_in;
    m_req  = nreq;
    m_id   = nid;
  endtask

  task automatic check_all();
    chk("irq_req",  32'(irq_req),   32'(m_req));
    chk("irq_id",   32'(irq_id),    32'(m_id));
    chk("irq_vec",  irq_vec,        32'h0000_4180 + 32'(m_id) * 32'h20);
    chk("epc_out",  epc_out,        epc_m());
    chk("depth",    32'(depth_out), 32'(m_stk.size()));
    chk("status",   status_out,     status_m());
    chk("cause",    cause_out,      cause_m());
    chk("cp_rd",    cp_rd,          rd_m(cp_ra));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic cp_write(input logic [4:0] a, input logic [31:0] d);
    cp_we = 1'b1; cp_wa = a; cp_wd = d;
    step();
    cp_we = 1'b0;
  endtask

  task automatic do_ack(input logic [31:0] pc);
    irq_ack = 1'b1; epc_in = pc;
    step();
    irq_ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    step();
    eret = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 12 && !irq_req; i++) step();
    chk(tag, 32'(irq_req), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  logic [4:0] ra_tab [7] = '{5'd12, 5'd13, 5'd14, 5'd22, 5'd23, 5'd0, 5'd31};
  logic [4:0] wa_tab [6] = '{5'd12, 5'd12, 5'd14, 5'd22, 5'd23, 5'd13};

  initial begin
    rst = 1'b1; irq_in = '0; irq_ack = 1'b0; eret = 1'b0; cp_we = 1'b0;
    epc_in = '0; cp_wd = '0; cp_wa = '0; cp_ra = 5'd13;

    // reset values
    do_reset();
    chk("rst_req",   32'(irq_req),   32'd0);
    chk("rst_cause", cause_out,      32'h0000_003C);
    chk("rst_stat",  status_out,     32'd0);
    chk("rst_depth", 32'(depth_out), 32'd0);

    // level line 3, request latency and vector
    cp_write(5'd12, 32'h0000_0801);
    irq_in[3] = 1'b1;
    step();
    step();
    chk("t1_req_early", 32'(irq_req), 32'd0);
    step();
    chk("t1_req",  32'(irq_req), 32'd1);
    chk("t1_id",   32'(irq_id),  32'd3);
    chk("t1_vec",  irq_vec,      32'h0000_41E0);
    do_ack(32'h0000_0100);
    chk("t1_depth", 32'(depth_out), 32'd1);
    chk("t1_epc",   epc_out,        32'h0000_0100);
    chk("t1_ie",    32'(status_out[0]), 32'd0);
    irq_in[3] = 1'b0;
    idle_steps(3);
    do_eret();
    chk("t1_eret_depth", 32'(depth_out), 32'd0);

    // nesting with a two-entry stack, then stack full
    do_reset();
    cp_write(5'd12, 32'h0000_FF01);
    irq_in[5] = 1'b1;
    wait_req("n_req5");
    chk("n_id5", 32'(irq_id), 32'd5);
    do_ack(32'h0000_0500);
    cp_write(5'd12, 32'h0000_FF01);
    irq_in[1] = 1'b1;
    wait_req("n_req1");
    chk("n_id1", 32'(irq_id), 32'd1);
    do_ack(32'h0000_1000);
    chk("n_depth2", 32'(depth_out), 32'd2);
    cp_write(5'd12, 32'h0000_FF01);
    irq_in[0] = 1'b1;
    idle_steps(5);
    chk("full_noreq", 32'(irq_req), 32'd0);
    irq_in = '0;
    idle_steps(3);
    do_eret();
    chk("n_eret_epc",   epc_out,         32'h0000_0500);
    chk("n_eret_level", 32'(cause_out[5:2]), 32'd5);
    do_eret();
    chk("n_eret2_depth", 32'(depth_out),     32'd0);
    chk("n_eret2_ie",    32'(status_out[0]), 32'd1);

    // priority and mask; late IM change does not move a latched id
    do_reset();
    cp_write(5'd12, 32'h0000_FB01);
    irq_in[2] = 1'b1; irq_in[6] = 1'b1;
    wait_req("p_req");
    chk("p_id6", 32'(irq_id), 32'd6);
    cp_write(5'd12, 32'h0000_FF01);
    step();
    chk("p_id_frozen", 32'(irq_id), 32'd6);
    do_ack(32'h0000_0600);
    chk("p_cause_lvl", 32'(cause_out[5:2]), 32'd6);
    irq_in = '0;
    idle_steps(3);
    do_eret();

    // edge-mode line 4
    do_reset();
    cp_write(5'd22, 32'h0000_0010);
    cp_write(5'd12, 32'h0000_1001);
    irq_in[4] = 1'b1;
    step();
    irq_in[4] = 1'b0;
    wait_req("e_req");
    chk("e_id", 32'(irq_id), 32'd4);
    cp_write(5'd23, 32'h0000_0010);
    step();
    chk("e_clear_drop", 32'(irq_req), 32'd0);
    irq_in[4] = 1'b1;
    wait_req("e_req2");
    do_ack(32'h0000_0400);
    do_eret();
    idle_steps(6);
    chk("e_no_retrig", 32'(irq_req), 32'd0);
    do_eret();
    chk("eret_empty_depth",  32'(depth_out), 32'd0);
    chk("eret_empty_status", status_out,     32'h0000_1001);
    irq_in = '0;
    idle_steps(3);

    // reset mid-request with depth 1
    do_reset();
    cp_write(5'd12, 32'h0000_FF01);
    irq_in[5] = 1'b1;
    wait_req("r_req5");
    do_ack(32'h0000_0777);
    cp_write(5'd12, 32'h0000_FF01);
    irq_in[2] = 1'b1;
    wait_req("r_req2");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r_req",   32'(irq_req),   32'd0);
    chk("r_id",    32'(irq_id),    32'd0);
    chk("r_epc",   epc_out,        32'd0);
    chk("r_depth", 32'(depth_out), 32'd0);
    chk("r_stat",  status_out,     32'd0);
    chk("r_cause", cause_out,      32'h0000_003C);
    irq_in = '0;

    // random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) irq_in[b] = ~irq_in[b];
      irq_ack = m_req && elig_m(m_id) && ($urandom_range(2) == 0);
      eret    = ($urandom_range(11) == 0);
      epc_in  = $urandom;
      cp_ra   = ra_tab[$urandom_range(6)];
      cp_we   = ($urandom_range(4) == 0);
      cp_wa   = wa_tab[$urandom_range(5)];
      cp_wd   = $urandom;
      if (cp_we && cp_wa == 5'd12 && $urandom_range(2) != 0) cp_wd[0] = 1'b1;
      if (cp_we && cp_wa == 5'd14 && (irq_ack || eret)) cp_we = 1'b0;
      rst = ($urandom_range(399) == 0);
      step();
    end
    rst = 1'b0; irq_ack = 1'b0; eret = 1'b0; cp_we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
